// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1-style UART receiver, LSB first.
// Drives the rx-clock enable of the baud generator and consumes its
// mid-bit tick. Every output comes straight from a flop.
module uart_rx_frame #(
  parameter int DATA_BITS   = 8,   // data bits per frame, 5..8
  parameter int SYNC_STAGES = 2    // synchronizer depth on I_rx, 2..3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 I_rx,
  input  logic                 I_baud_tick,
  output logic                 O_baud_en,
  output logic [DATA_BITS-1:0] O_data,
  output logic                 O_data_valid,
  output logic                 O_frame_err,
  output logic                 O_busy
);

  localparam int CNT_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_d, fall;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   valid_d, err_d;

  assign rx_s = sync_q[SYNC_STAGES-1];
  // A start edge needs the line to have been high the cycle before, so a
  // line held low (break) can never arm a new frame until it returns high.
  assign fall = rx_d & ~rx_s;

  // Synchronizer plus one history flop; reset to the idle (high) level so
  // reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I_rx};
      rx_d   <= rx_s;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      O_data       <= '0;
      O_data_valid <= 1'b0;
      O_frame_err  <= 1'b0;
      O_baud_en    <= 1'b0;
      O_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      O_data       <= data_d;
      O_data_valid <= valid_d;
      O_frame_err  <= err_d;
      // Enable and busy follow the next state, so they drop in the same
      // cycle the FSM returns to IDLE (stop exit or false start).
      O_baud_en    <= (state_d != IDLE);
      O_busy       <= (state_d != IDLE);
    end
  end

  // Next-state and next-output logic; ticks are only looked at outside IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = O_data;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (I_baud_tick) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            // Glitch shorter than half a bit: quietly give up.
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (I_baud_tick) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BITS-1)) state_d = STOP;
        end
      end
      STOP: begin
        if (I_baud_tick) begin
          // The byte is exposed on a framing error too, for diagnostics.
          data_d  = shreg_q;
          valid_d = rx_s;
          err_d   = ~rx_s;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of whole frames plus hand-written
// sequences for false start, break, reset mid-frame and a 5-bit instance.
module tb_uart_rx_frame;

  localparam int BIT_T   = 434;  // clocks per bit
  localparam int FIRST_T = 216;  // clocks from enable to first tick

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       rx8 = 1'b1, tick8 = 1'b0;
  logic       en8, valid8, err8, busy8;
  logic [7:0] data8;
  logic       rx5 = 1'b1, tick5 = 1'b0;
  logic       en5, valid5, err5, busy5;
  logic [4:0] data5;

  uart_rx_frame #(.DATA_BITS(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .I_rx(rx8), .I_baud_tick(tick8),
    .O_baud_en(en8), .O_data(data8), .O_data_valid(valid8),
    .O_frame_err(err8), .O_busy(busy8)
  );

  uart_rx_frame #(.DATA_BITS(5), .SYNC_STAGES(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .I_rx(rx5), .I_baud_tick(tick5),
    .O_baud_en(en5), .O_data(data5), .O_data_valid(valid5),
    .O_frame_err(err5), .O_busy(busy5)
  );

  // Baud generator models: counter clears while enable is low, first tick
  // half a bit after enable, then one per bit period.
  int   bcnt8 = 0, bcnt5 = 0;
  logic first8 = 1'b1, first5 = 1'b1;

  always @(posedge clk) begin
    if (!en8) begin
      bcnt8 <= 0; first8 <= 1'b1; tick8 <= 1'b0;
    end else if (bcnt8 == (first8 ? FIRST_T-1 : BIT_T-1)) begin
      bcnt8 <= 0; first8 <= 1'b0; tick8 <= 1'b1;
    end else begin
      bcnt8 <= bcnt8 + 1; tick8 <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!en5) begin
      bcnt5 <= 0; first5 <= 1'b1; tick5 <= 1'b0;
    end else if (bcnt5 == (first5 ? FIRST_T-1 : BIT_T-1)) begin
      bcnt5 <= 0; first5 <= 1'b0; tick5 <= 1'b1;
    end else begin
      bcnt5 <= bcnt5 + 1; tick5 <= 1'b0;
    end
  end

  // Pulse monitors: count pulses and flag protocol violations (both pulses
  // at once, pulse not 1 clk after a tick, pulse wider than 1 clk, enable
  // dropping without a preceding tick).
  int   nvalid8 = 0, nerr8 = 0, nbad8 = 0, nvalid5 = 0, nerr5 = 0;
  logic prev_tick8 = 1'b0, prev_pulse8 = 1'b0, prev_en8 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid8 || err8) begin
        if (valid8) nvalid8 <= nvalid8 + 1;
        if (err8)   nerr8   <= nerr8 + 1;
        if ((valid8 && err8) || !prev_tick8 || prev_pulse8) nbad8 <= nbad8 + 1;
      end
      if (prev_en8 && !en8 && !prev_tick8) nbad8 <= nbad8 + 1;
      if (valid5) nvalid5 <= nvalid5 + 1;
      if (err5)   nerr5   <= nerr5 + 1;
    end
    prev_tick8  <= tick8;
    prev_pulse8 <= valid8 | err8;
    prev_en8    <= en8;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame8(input logic [7:0] b, input logic stop);
    rx8 = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("en_before_sync", en8, 0);
    @(negedge clk);
    chk("en_after_edge", en8, 1);
    chk("busy_in_frame", busy8, 1);
    repeat (BIT_T-3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx8 = b[i];
      repeat (BIT_T) @(negedge clk);
    end
    rx8 = stop;
    repeat (BIT_T) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs[5];
  int         nv0, ne0;
  logic [7:0] b81;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, BIT_T, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,     1, 0, 8'h00};  // back-to-back into next
    vecs[2] = '{8'hFF, 1'b1, BIT_T, 1, 0, 8'hFF};
    vecs[3] = '{8'h96, 1'b0, BIT_T, 0, 1, 8'h96};  // framing error
    vecs[4] = '{8'h01, 1'b1, BIT_T, 1, 0, 8'h01};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_en", en8, 0);
    chk("rst_data", data8, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_err", err8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_data5", data5, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table of whole frames
    for (int v = 0; v < 5; v++) begin
      nv0 = nvalid8; ne0 = nerr8;
      send_frame8(vecs[v].data, vecs[v].stop);
      chk("tbl_valid_cnt", nvalid8 - nv0, vecs[v].exp_valid);
      chk("tbl_err_cnt", nerr8 - ne0, vecs[v].exp_err);
      chk("tbl_data", data8, vecs[v].exp_data);
      rx8 = 1'b1;
      if (vecs[v].gap > 0) begin
        repeat (vecs[v].gap) @(negedge clk);
        chk("tbl_en_idle", en8, 0);
        chk("tbl_busy_idle", busy8, 0);
      end
    end

    // False start: 100-clk low glitch
    nv0 = nvalid8; ne0 = nerr8;
    rx8 = 1'b0;
    repeat (100) @(negedge clk);
    chk("glitch_en_up", en8, 1);
    rx8 = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_en_down", en8, 0);
    chk("glitch_busy", busy8, 0);
    chk("glitch_valid", nvalid8 - nv0, 0);
    chk("glitch_err", nerr8 - ne0, 0);
    chk("glitch_data", data8, 8'h01);

    // Framing error followed by a 5-bit-period break, then recovery
    nv0 = nvalid8; ne0 = nerr8;
    send_frame8(8'h3C, 1'b0);
    chk("brk_err_cnt", nerr8 - ne0, 1);
    chk("brk_data", data8, 8'h3C);
    repeat (5*BIT_T) @(negedge clk);
    chk("brk_en_low", en8, 0);
    chk("brk_busy_low", busy8, 0);
    chk("brk_no_frame_v", nvalid8 - nv0, 0);
    chk("brk_no_frame_e", nerr8 - ne0, 1);
    rx8 = 1'b1;
    repeat (BIT_T) @(negedge clk);
    send_frame8(8'h5A, 1'b1);
    chk("rec_valid_cnt", nvalid8 - nv0, 1);
    chk("rec_data", data8, 8'h5A);
    rx8 = 1'b1;
    repeat (BIT_T) @(negedge clk);

    // Reset during data bit 4 of 0x81
    nv0 = nvalid8; ne0 = nerr8;
    b81 = 8'h81;
    rx8 = 1'b0;
    repeat (BIT_T) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx8 = b81[i];
      repeat (BIT_T) @(negedge clk);
    end
    rx8 = b81[4];
    repeat (200) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_en", en8, 0);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_data", data8, 0);
    chk("mid_rst_pulses", {30'd0, valid8, err8}, 0);
    rx8 = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (BIT_T) @(negedge clk);
    chk("mid_rst_no_pulse", (nvalid8 - nv0) + (nerr8 - ne0), 0);
    send_frame8(8'h7E, 1'b1);
    chk("post_rst_valid", nvalid8 - nv0, 1);
    chk("post_rst_err", nerr8 - ne0, 0);
    chk("post_rst_data", data8, 8'h7E);
    rx8 = 1'b1;
    repeat (20) @(negedge clk);

    // 5-bit instance: 0x15, LSB first
    b81 = 8'h15;
    rx5 = 1'b0;
    repeat (BIT_T) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx5 = b81[i];
      repeat (BIT_T) @(negedge clk);
    end
    rx5 = 1'b1;
    repeat (BIT_T) @(negedge clk);
    chk("d5_data", data5, 5'h15);
    chk("d5_valid_cnt", nvalid5, 1);
    chk("d5_err_cnt", nerr5, 0);
    chk("d5_en_idle", en5, 0);

    chk("protocol_violations", nbad8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receiver that turns the serial line into parallel bytes, one per frame: 8N1, LSB first.
- Drives the rx-clock enable of the team's baud rate generator and consumes its mid-bit rx tick.
  - Generator contract: the first tick arrives half a bit period after the enable rises.
  - Later ticks arrive once per bit period.
  - The generator counter clears while the enable is low.
- Sits between the pad-side rx pin and the byte consumer (command parser or FIFO).

Parameters:
- DATA_BITS, 8, data bits per frame (legal 5..8).
- SYNC_STAGES, 2, flip-flop stages in the I_rx synchronizer (legal 2..3).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- I_rx  input  1  asynchronous serial input; idle high.
- I_baud_tick  input  1  one-clk mid-bit sample strobe from the baud generator.
- O_baud_en  output  1  rx-clock enable to the baud generator; registered.
- O_data  output  DATA_BITS  last received byte, LSB = first data bit.
- O_data_valid  output  1  one-clk pulse when a frame ends with a valid stop bit.
- O_frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- O_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all synchronizer stages and the edge-history flop = 1.
  - O_baud_en=0, O_data=0, O_data_valid=0, O_frame_err=0, O_busy=0.
  - bit counter = 0, shift register = 0.
- Synchronizer:
  - I_rx passes through SYNC_STAGES flip-flops to give rx_s.
  - One more history flop gives rx_d.
  - Falling edge = rx_d & ~rx_s.
- FSM states: IDLE, START, DATA, STOP. All outputs are registered.
- IDLE:
  - O_baud_en=0; I_baud_tick is ignored.
  - A falling edge moves to START and sets O_baud_en=1 on the next clk edge.
- START: on I_baud_tick, sample rx_s.
  - rx_s=0: go to DATA with bit counter = 0.
  - rx_s=1: false start; go to IDLE, drop O_baud_en, no output pulse.
- DATA: on each I_baud_tick:
  - Shift register <= {rx_s, shreg[DATA_BITS-1:1]}; bit counter += 1.
  - When the counter reaches DATA_BITS-1 on a tick, that tick shifts the last bit and moves to STOP.
- STOP: on I_baud_tick, sample rx_s, load O_data <= shift register, then:
  - rx_s=1: O_data_valid=1 for exactly one clk.
  - rx_s=0: O_frame_err=1 for exactly one clk.
  - In both cases go to IDLE and drop O_baud_en in the same cycle.
- O_data holds its value until the next completed frame; it is also updated on a framing error.
- O_data_valid and O_frame_err are mutually exclusive and never asserted outside the STOP-exit cycle.
- Line held low after a framing error (break):
  - No new frame is armed, because a falling edge needs rx_s=1 first.
  - The receiver re-arms only after the line has returned high.
- Back-to-back frames:
  - A start edge arriving in the same cycle as the STOP-exit is lost; tolerated, since it cannot happen at legal baud rates with the mid-bit stop sample.
  - An edge one or more cycles after the exit must be captured.
- Ticks in adjacent cycles are legal; each tick is consumed exactly once.
- Latency: O_data_valid rises 1 clk after the stop-bit tick.
- Reset mid-frame: returns to IDLE immediately; no pulse; O_baud_en=0.

Test Plan:
- Generator at C_baud_sel=433 (434-clk bit period, first tick 216 clk after enable).
  - Send 0xA5 with stop=1.
  - Required: O_data=0xA5 and exactly one O_data_valid pulse.
  - O_frame_err stays 0.
  - O_baud_en high from 1 clk after the synced edge until the stop tick.
- Low glitch of 100 clk on an idle line.
  - Required: the START tick sees 1 and the FSM returns to IDLE.
  - O_data_valid=0, O_frame_err=0, O_data unchanged, O_baud_en falls.
- Send 0x3C with stop bit = 0, then hold the line low for 5 bit periods.
  - Required: exactly one O_frame_err pulse and O_data=0x3C.
  - No new frame while the line stays low.
  - Normal reception of 0x5A after the line returns high.
- Back-to-back 0x00 then 0xFF, no idle gap beyond the stop bit.
  - Required: two valid pulses carrying 0x00 and 0xFF, no errors.
- Assert rst_n=0 during data bit 4 of 0x81, then release and send 0x7E.
  - Required: all outputs 0 during reset, no pulse for 0x81.
  - O_data=0x7E with one valid pulse.
- DATA_BITS=5: send 0x15.
  - Required: O_data=5'h15 after 5 data ticks and one valid pulse.
